python_encode: RTL and testbench

PYTHON_ENCODE -- requirements
Module: python_encode

---
 rtl/python_pkg.sv | 12 +
 rtl/python_lane_xor.sv | 16 +
 rtl/python_encode.sv | 112 +++++++++++
 tb/tb_python_encode.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/python_pkg.sv
// python_pkg: code words, pixel width and state encoding shared by the encoder and decoder.
package python_pkg;
  localparam int DEF_PIXEL_BITS = 10;
  localparam logic [9:0] DEF_FS = 10'h2AA;
  localparam logic [9:0] DEF_LS = 10'h0AA;
  localparam logic [9:0] DEF_FE = 10'h3AA;
  localparam logic [9:0] DEF_LE = 10'h12A;
  localparam logic [9:0] DEF_IMG = 10'h035;
  localparam logic [9:0] DEF_CRC = 10'h059;
  localparam logic [9:0] DEF_TR = 10'h3A6;
  typedef enum logic [2:0] {IDLE, LINE, CRCW, HBLK, VBLK} state_t;
endpackage

// File: rtl/python_lane_xor.sv
// python_lane_xor: per-lane running XOR checksum of the pixels sent in one line.
module python_lane_xor #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc ^ din;
endmodule

// File: rtl/python_encode.sv
// python_encode: frames pixel kernels into a sync channel plus CH data lanes with per-line XOR checksums.
module python_encode
  import python_pkg::*;
#(
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter logic [PIXEL_BITS-1:0] FS = PIXEL_BITS'(DEF_FS),
  parameter logic [PIXEL_BITS-1:0] LS = PIXEL_BITS'(DEF_LS),
  parameter logic [PIXEL_BITS-1:0] FE = PIXEL_BITS'(DEF_FE),
  parameter logic [PIXEL_BITS-1:0] LE = PIXEL_BITS'(DEF_LE),
  parameter logic [PIXEL_BITS-1:0] IMG = PIXEL_BITS'(DEF_IMG),
  parameter logic [PIXEL_BITS-1:0] CRC = PIXEL_BITS'(DEF_CRC),
  parameter logic [PIXEL_BITS-1:0] TR = PIXEL_BITS'(DEF_TR),
  parameter int CH = 4,
  parameter int WIDTH_BITS = 12,
  parameter int HEIGHT_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [WIDTH_BITS-1:0]    hsize,
  input  logic [HEIGHT_BITS-1:0]   vsize,
  input  logic [WIDTH_BITS-1:0]    hblank,
  input  logic [WIDTH_BITS-1:0]    vblank,
  input  logic [CH*PIXEL_BITS-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PIXEL_BITS-1:0]    sync,
  output logic [CH*PIXEL_BITS-1:0] dout,
  output logic                     busy,
  output logic                     underflow
);
  localparam int W = CH * PIXEL_BITS;
  state_t state;
  logic [WIDTH_BITS-1:0] h_l, hb_l, vb_l, hcnt, bcnt;
  logic [HEIGHT_BITS-1:0] v_l, vcnt;
  logic [W-1:0] acc, kernel;
  logic [PIXEL_BITS-1:0] line_code;
  logic take, last_k, last_line, blk_end, frame_end, start;
  assign in_ready = state == LINE;
  assign take = in_ready && in_valid;
  assign kernel = in_valid ? in_data : '0;
  assign last_k = hcnt == h_l - WIDTH_BITS'(1);
  assign last_line = vcnt == v_l - HEIGHT_BITS'(1);
  assign blk_end = bcnt == (state == HBLK ? hb_l : vb_l) - WIDTH_BITS'(1);
  assign frame_end = (state == CRCW && last_line && vb_l == '0) || (state == VBLK && blk_end);
  assign start = enable && (state == IDLE || frame_end);
  assign line_code = hcnt == '0 ? (vcnt == '0 ? FS : LS) : last_k ? (last_line ? FE : LE) : IMG;
  for (genvar l = 0; l < CH; l++) begin : g_lane
    python_lane_xor #(.W(PIXEL_BITS)) u_xor (
      .clk(clk),
      .rst(rst),
      .en(take),
      .clr(state == CRCW),
      .din(in_data[l*PIXEL_BITS +: PIXEL_BITS]),
      .acc(acc[l*PIXEL_BITS +: PIXEL_BITS])
    );
  end
  // Sizes are sampled only when a frame starts so mid-frame input changes are ignored.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      h_l <= '0;
      v_l <= '0;
      hb_l <= '0;
      vb_l <= '0;
      hcnt <= '0;
      vcnt <= '0;
      bcnt <= '0;
    end else if (start) begin
      state <= LINE;
      h_l <= hsize < WIDTH_BITS'(2) ? WIDTH_BITS'(2) : hsize;
      v_l <= vsize == '0 ? HEIGHT_BITS'(1) : vsize;
      hb_l <= hblank;
      vb_l <= vblank;
      hcnt <= '0;
      vcnt <= '0;
      bcnt <= '0;
    end else
      case (state)
        LINE: begin
          hcnt <= last_k ? '0 : hcnt + WIDTH_BITS'(1);
          if (last_k) state <= CRCW;
        end
        CRCW: begin
          bcnt <= '0;
          state <= !last_line ? (hb_l == '0 ? LINE : HBLK) : (vb_l == '0 ? IDLE : VBLK);
          if (!last_line && hb_l == '0) vcnt <= vcnt + HEIGHT_BITS'(1);
        end
        HBLK:
          if (blk_end) begin
            state <= LINE;
            vcnt <= vcnt + HEIGHT_BITS'(1);
          end else bcnt <= bcnt + WIDTH_BITS'(1);
        VBLK:
          if (blk_end) state <= IDLE;
          else bcnt <= bcnt + WIDTH_BITS'(1);
        default: ;
      endcase
  // Output stage lags the state by one cycle so a kernel and its sync word leave together.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= TR;
      dout <= {CH{TR}};
      busy <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sync <= state == LINE ? line_code : state == CRCW ? CRC : TR;
      dout <= state == LINE ? kernel : state == CRCW ? acc : {CH{TR}};
      busy <= state != IDLE;
      underflow <= underflow || (in_ready && !in_valid);
    end
endmodule

// File: tb/tb_python_encode.sv
// tb_python_encode: table-driven frame scoreboard with stream decode, plus a mid-line reset sequence.
module tb_python_encode;
  import python_pkg::*;
  localparam int PB = 10, CH = 4, WB = 12, HB = 12, W = CH * PB;
  logic clk = 1'b0, rst, enable, in_valid, in_ready, busy, underflow;
  logic [WB-1:0] hsize, hblank, vblank;
  logic [HB-1:0] vsize;
  logic [W-1:0] in_data, dout;
  logic [PB-1:0] sync;
  always #5 clk = ~clk;
  python_encode dut (
    .clk(clk), .rst(rst), .enable(enable), .hsize(hsize), .vsize(vsize),
    .hblank(hblank), .vblank(vblank), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sync(sync), .dout(dout), .busy(busy), .underflow(underflow)
  );
  typedef struct {
    int h, v, hb, vb, uf, pat, keep;
    int exp_h, exp_v, exp_len, exp_uf, exp_post, exp_busy;
  } vec_t;
  typedef struct {
    logic [PB-1:0] s;
    logic [W-1:0]  d;
  } exp_t;
  exp_t q[$];
  logic [W-1:0] data[$];
  vec_t vecs[8];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build(input vec_t v);
    logic [W-1:0] d, crc;
    logic [PB-1:0] s;
    int slot;
    data.delete();
    q.delete();
    for (int i = 0; i < v.exp_h * v.exp_v; i++)
      data.push_back(v.pat != 0 ? {CH{PB'(1 << (i % v.exp_h))}} : W'({$urandom(), $urandom()}));
    crc = '0;
    slot = 0;
    for (int li = 0; li < v.exp_v; li++) begin
      for (int k = 0; k < v.exp_h; k++) begin
        s = k == 0 ? (li == 0 ? DEF_FS : DEF_LS) : k == v.exp_h - 1 ? (li == v.exp_v - 1 ? DEF_FE : DEF_LE) : DEF_IMG;
        d = slot == v.uf ? '0 : data[slot];
        crc ^= d;
        q.push_back('{s, d});
        slot++;
      end
      q.push_back('{DEF_CRC, crc});
      crc = '0;
      for (int b = 0; b < (li < v.exp_v - 1 ? v.hb : v.vb); b++) q.push_back('{DEF_TR, {CH{DEF_TR}}});
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    exp_t e;
    int slot, cyc, bcount, kcount, hdec, vdec;
    bit started;
    rst = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d rst sync", n), W'(sync), W'(DEF_TR));
    chk($sformatf("v%0d rst dout", n), dout, {CH{DEF_TR}});
    chk($sformatf("v%0d rst in_ready", n), W'(in_ready), '0);
    chk($sformatf("v%0d rst busy", n), W'(busy), '0);
    chk($sformatf("v%0d rst underflow", n), W'(underflow), '0);
    rst = 1'b0;
    hsize = WB'(v.h);
    vsize = HB'(v.v);
    hblank = WB'(v.hb);
    vblank = WB'(v.vb);
    enable = 1'b1;
    build(v);
    started = 0;
    slot = 0;
    cyc = 0;
    bcount = 0;
    kcount = 0;
    hdec = 0;
    vdec = 0;
    while (q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!started && sync == DEF_FS) started = 1;
      if (started) begin
        e = q.pop_front();
        chk($sformatf("v%0d sync", n), W'(sync), W'(e.s));
        chk($sformatf("v%0d dout", n), dout, e.d);
        if (busy) bcount++;
        if (sync inside {DEF_FS, DEF_LS, DEF_IMG, DEF_LE, DEF_FE}) kcount++;
        if (sync == DEF_LE || sync == DEF_FE) begin
          if (vdec == 0) hdec = kcount;
          vdec++;
        end
      end
      if (in_ready) begin
        in_valid = slot != v.uf;
        in_data = slot < data.size() ? data[slot] : '0;
        slot++;
        if (v.keep == 0) enable = 1'b0;
        hsize = WB'($urandom);
        vsize = HB'($urandom);
        hblank = WB'($urandom_range(0, 7));
        vblank = WB'($urandom_range(0, 7));
      end
    end
    chk($sformatf("v%0d frame timeout", n), W'(q.size()), '0);
    @(negedge clk);
    chk($sformatf("v%0d post sync", n), W'(sync), W'(v.exp_post));
    chk($sformatf("v%0d post busy", n), W'(busy), W'(v.exp_busy));
    chk($sformatf("v%0d underflow", n), W'(underflow), W'(v.exp_uf));
    chk($sformatf("v%0d busy cycles", n), W'(bcount), W'(v.exp_len));
    chk($sformatf("v%0d decoded hsize", n), W'(hdec), W'(v.exp_h));
    chk($sformatf("v%0d decoded vsize", n), W'(vdec), W'(v.exp_v));
  endtask

  initial begin
    int tr, fs, cyc;
    tr = int'(DEF_TR);
    fs = int'(DEF_FS);
    //         h  v hb vb uf pat keep eh ev len uf post busy
    vecs[0] = '{3, 2, 2, 4, -1, 0, 0, 3, 2, 14, 0, tr, 0};
    vecs[1] = '{3, 2, 2, 4, -1, 0, 1, 3, 2, 14, 0, fs, 1};
    vecs[2] = '{1, 0, 3, 1, -1, 0, 0, 2, 1, 4, 0, tr, 0};
    vecs[3] = '{3, 1, 0, 0, 1, 0, 0, 3, 1, 4, 1, tr, 0};
    vecs[4] = '{3, 1, 1, 2, -1, 1, 0, 3, 1, 6, 0, tr, 0};
    vecs[5] = '{5, 3, 0, 2, -1, 0, 0, 5, 3, 20, 0, tr, 0};
    vecs[6] = '{2, 2, 1, 0, -1, 0, 0, 2, 2, 7, 0, tr, 0};
    vecs[7] = '{0, 1, 0, 0, -1, 0, 0, 2, 1, 3, 0, tr, 0};
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    rst = 1'b1;
    enable = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hsize = 12'd4;
    vsize = 12'd2;
    hblank = 12'd1;
    vblank = 12'd1;
    enable = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("midreset reach line", W'(in_ready), W'(1));
    repeat (2) @(negedge clk);
    chk("midreset underflow set", W'(underflow), W'(1));
    rst = 1'b1;
    #1;
    chk("midreset sync", W'(sync), W'(DEF_TR));
    chk("midreset in_ready", W'(in_ready), '0);
    chk("midreset underflow", W'(underflow), '0);
    chk("midreset busy", W'(busy), '0);
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("midreset after sync", W'(sync), W'(DEF_TR));
    chk("midreset after busy", W'(busy), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
